chain_rx: RTL and testbench
===========================

CHAIN_RX -- requirements
Module: chain_rx

Interface
REQ-001 The module SHALL have parameter DIV, default 4, meaning clock cycles per serial bit period (legal range 2..255).
REQ-002 The module SHALL have parameter PARITY_EN, default 1, meaning that an even-parity bit follows the data bits when 1.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port din, input, 1 bit: serial line, idle high, driven by the matching chain transmitter.
REQ-006 The module SHALL have port dout, output, 8 bits: received byte at the head of the output buffer.
REQ-007 The module SHALL have port dout_vld, output, 1 bit: dout holds a valid byte.
REQ-008 The module SHALL have port dout_rdy, input, 1 bit: the consumer accepts dout.
REQ-009 The module SHALL have port err_parity, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-010 The module SHALL have port err_frame, output, 1 bit: one-cycle pulse when the sampled stop bit is 0.
REQ-011 The module SHALL have port ovf, output, 1 bit: sticky flag set when a good byte is dropped because the buffer is full.

Function
REQ-012 The module SHALL register din through a 2-flop synchronizer; all references to the line below mean the synchronized value.
REQ-013 The module SHALL implement states IDLE, START, DATA, PAR, STOP.
REQ-014 In IDLE, on a line falling edge (1 then 0), the module SHALL load the bit counter with DIV/2 - 1 and enter START.
REQ-015 In START, at counter expiry, the module SHALL sample the line: 0 enters DATA with the counter at DIV-1; 1 is a glitch and returns to IDLE with no error.
REQ-016 In DATA, the module SHALL sample one bit every DIV cycles, LSB first, for 8 bits, then enter PAR if PARITY_EN is 1, otherwise STOP.
REQ-017 In PAR, the module SHALL sample one bit and compare it with the XOR of the 8 data bits; a mismatch pulses err_parity in the cycle after the sample.
REQ-018 In STOP, the module SHALL sample one bit: 0 pulses err_frame; in either case it returns to IDLE the next cycle.
REQ-019 A byte SHALL be pushed into the buffer only if both the stop and parity checks pass; bytes with errors are discarded.
REQ-020 The output buffer SHALL be a 2-entry FIFO; dout and dout_vld SHALL come directly from registers, with no combinational path from din.
REQ-021 A transfer SHALL occur in each cycle where dout_vld and dout_rdy are both 1; dout SHALL stay stable while dout_vld=1 and dout_rdy=0.
REQ-022 A push and a pop in the same cycle with the buffer full SHALL both succeed, leaving the occupancy at 2 with no overflow.
REQ-023 A push to a full buffer with no pop SHALL drop the byte and set ovf; ovf SHALL clear only on rst.
REQ-024 Latency SHALL be: dout_vld rises 1 cycle after the stop-bit sample when the buffer is empty.
REQ-025 The module SHALL ignore a falling edge of the line while not in IDLE.
REQ-026 The module SHALL NOT check for a new start bit until IDLE is re-entered.

Reset
REQ-027 On rst, the module SHALL set the state to IDLE, clear the counters and FIFO pointers, and set dout=0, dout_vld=0, err_parity=0, err_frame=0, ovf=0.
REQ-028 On rst, the synchronizer flops SHALL load 1 (idle line).
REQ-029 Reset asserted mid-frame SHALL abandon the frame; no partial byte SHALL be delivered afterwards.

Structure
REQ-030 A shared package chain_pkg SHALL hold the state enum, the data width constant (8), and the parity helper function.
REQ-031 The 2-entry FIFO SHALL be a sub-module named chain_fifo2, parameterized by width.
REQ-032 Total RTL SHALL be 120-400 lines.

Verification
REQ-033 Scenario: DIV=4, frame 0xA5 with correct parity and stop=1, dout_rdy=1 -> dout=0xA5, dout_vld high for one cycle, no errors.
REQ-034 Scenario: 0x3C sent with the wrong parity bit -> err_parity pulses once, dout_vld stays 0.
REQ-035 Scenario: 0x81 sent with stop=0 -> err_frame pulses once, no byte delivered, next frame 0x01 received correctly.
REQ-036 Scenario: dout_rdy=0 while 3 frames 0x11, 0x22, 0x33 are sent -> buffer holds 0x11 and 0x22, ovf=1; releasing dout_rdy yields 0x11 then 0x22.
REQ-037 Scenario: din low for 1 cycle only (glitch) -> return to IDLE, no output, no error.
REQ-038 Scenario: rst asserted during DATA bit 4 -> all outputs 0; a following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/chain_pkg.sv
// Shared types and helpers for the chain serial receiver.
package chain_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_e;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/chain_fifo2.sv
// Two-entry output buffer; head entry is a register so dout is glitch-free.
module chain_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  input  logic         dout_rdy,
  output logic         drop
);
  logic [W-1:0] ent1;
  logic         vld1;
  logic         pop;

  assign pop  = dout_vld && dout_rdy;
  assign drop = push && vld1 && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      ent1     <= '0;
      vld1     <= 1'b0;
    end else if (pop) begin
      // Head leaves; second entry moves up, new byte fills behind it.
      if (vld1) begin
        dout <= ent1;
        if (push) ent1 <= wdata;
        else      vld1 <= 1'b0;
      end else if (push) begin
        dout <= wdata;
      end else begin
        dout_vld <= 1'b0;
      end
    end else if (push) begin
      if (!dout_vld) begin
        dout     <= wdata;
        dout_vld <= 1'b1;
      end else if (!vld1) begin
        ent1 <= wdata;
        vld1 <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/chain_rx.sv
// Serial frame receiver: start, 8 data bits LSB first, optional even parity, stop.
module chain_rx
  import chain_pkg::*;
#(
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              err_parity,
  output logic              err_frame,
  output logic              ovf
);
  localparam logic [7:0] HALF = 8'(DIV/2 - 1);
  localparam logic [7:0] FULL = 8'(DIV - 1);

  logic              s1, s2, line_d;
  rx_state_e         state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [2:0]        idx, idx_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              par_bad, par_bad_n;
  logic              par_err_n, frm_err_n, push, drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, line_d} <= 3'b111;
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      par_bad    <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      s1         <= din;
      s2         <= s1;
      line_d     <= s2;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      par_bad    <= par_bad_n;
      err_parity <= par_err_n;
      err_frame  <= frm_err_n;
      if (drop) ovf <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    sh_n      = sh;
    par_bad_n = par_bad;
    par_err_n = 1'b0;
    frm_err_n = 1'b0;
    push      = 1'b0;
    case (state)
      ST_IDLE: if (line_d && !s2) begin
        cnt_n   = HALF;
        state_n = ST_START;
      end
      ST_START: if (cnt == 8'd0) begin
        // A line back high at mid-start is treated as noise.
        if (!s2) begin
          state_n   = ST_DATA;
          cnt_n     = FULL;
          idx_n     = '0;
          par_bad_n = 1'b0;
        end else begin
          state_n = ST_IDLE;
        end
      end else cnt_n = cnt - 8'd1;
      ST_DATA: if (cnt == 8'd0) begin
        sh_n  = {s2, sh[DATA_W-1:1]};
        cnt_n = FULL;
        idx_n = idx + 3'd1;
        if (idx == 3'd7) state_n = (PARITY_EN != 0) ? ST_PAR : ST_STOP;
      end else cnt_n = cnt - 8'd1;
      ST_PAR: if (cnt == 8'd0) begin
        par_bad_n = (s2 != even_par(sh));
        par_err_n = par_bad_n;
        cnt_n     = FULL;
        state_n   = ST_STOP;
      end else cnt_n = cnt - 8'd1;
      ST_STOP: if (cnt == 8'd0) begin
        frm_err_n = !s2;
        push      = s2 && !par_bad;
        state_n   = ST_IDLE;
      end else cnt_n = cnt - 8'd1;
      default: state_n = ST_IDLE;
    endcase
  end

  chain_fifo2 #(.W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (sh),
    .dout    (dout),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .drop    (drop)
  );
endmodule

// File: tb/tb_chain_rx.sv
// Directed and randomized frames against a frame-level reference model.
module tb_chain_rx;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic [7:0] dout;
  logic       dout_vld;
  logic       dout_rdy = 1'b1;
  logic       err_parity, err_frame, ovf;

  int passed = 0, total = 0, failed = 0;
  logic [7:0] got[$];
  logic [7:0] mq[$];
  int np = 0, nf = 0, nvld = 0;
  int exp_np = 0, exp_nf = 0, exp_rx = 0;
  bit exp_ovf = 1'b0;

  chain_rx #(.DIV(DIV), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .dout_vld(dout_vld),
    .dout_rdy(dout_rdy), .err_parity(err_parity), .err_frame(err_frame), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst) begin
    if (dout_vld && dout_rdy) got.push_back(dout);
    if (dout_vld) nvld++;
    if (err_parity) np++;
    if (err_frame) nf++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_t(input logic b);
    din = b;
    tick(DIV);
  endtask

  task automatic send(input logic [7:0] d, input bit flip, input bit stop);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(d[i]);
    bit_t((^d) ^ flip);
    bit_t(stop);
    din = 1'b1;
    tick(2*DIV + 6);
  endtask

  // Frame-level model: good frames enter a 2-deep buffer, drained at once when ready.
  task automatic frame(input logic [7:0] d, input bit flip, input bit stop);
    send(d, flip, stop);
    exp_np += int'(flip);
    exp_nf += int'(!stop);
    if (!flip && stop) begin
      if (mq.size() < 2) mq.push_back(d);
      else exp_ovf = 1'b1;
    end
    if (dout_rdy) begin
      exp_rx += mq.size();
      mq.delete();
    end
    chk("rx_count", got.size(), exp_rx);
    if (!flip && stop && dout_rdy) chk("rx_byte", got[$], d);
    chk("parity_errs", np, exp_np);
    chk("frame_errs", nf, exp_nf);
    chk("ovf", ovf, exp_ovf);
  endtask

  initial begin
    tick(3);
    chk("rst_dout", dout, 8'h00);
    chk("rst_vld", dout_vld, 1'b0);
    chk("rst_errs", {err_parity, err_frame, ovf}, 3'b000);
    rst = 1'b0;
    tick(4);

    frame(8'hA5, 1'b0, 1'b1);
    chk("a5_vld_one_cycle", nvld, 1);
    frame(8'h3C, 1'b1, 1'b1);
    chk("3c_no_vld", nvld, 1);
    frame(8'h81, 1'b0, 1'b0);
    frame(8'h01, 1'b0, 1'b1);

    // Single-cycle low: must be discarded as noise.
    din = 1'b0; tick(1); din = 1'b1; tick(4*DIV);
    chk("glitch_rx", got.size(), exp_rx);
    chk("glitch_errs", np + nf, exp_np + exp_nf);

    for (int k = 0; k < 16; k++) begin
      frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end

    dout_rdy = 1'b0;
    frame(8'h11, 1'b0, 1'b1);
    chk("hold_dout", dout, 8'h11);
    frame(8'h22, 1'b0, 1'b1);
    chk("hold_dout2", dout, 8'h11);
    frame(8'h33, 1'b0, 1'b1);
    chk("full_vld", dout_vld, 1'b1);
    chk("full_dout", dout, 8'h11);
    dout_rdy = 1'b1;
    tick(4);
    chk("drain_count", got.size(), exp_rx + 2);
    chk("drain_first", got[got.size()-2], 8'h11);
    chk("drain_last", got[$], 8'h22);
    exp_rx += 2;
    mq.delete();
    tick(2);
    chk("drain_empty", dout_vld, 1'b0);

    // Abort a frame during data bit 4.
    bit_t(1'b0);
    for (int i = 0; i < 4; i++) bit_t(1'b1);
    din = 1'b0;
    tick(DIV/2);
    rst = 1'b1;
    din = 1'b1;
    tick(2);
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_flags", {dout_vld, err_parity, err_frame, ovf}, 4'b0000);
    rst = 1'b0;
    exp_ovf = 1'b0;
    tick(14*DIV);
    chk("midrst_no_partial", got.size(), exp_rx);
    frame(8'h5A, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
